// File: rtl/ccff_bitstream_loader_pkg.sv
// Shared types and constants for the configuration-chain loader.
package ccff_loader_pkg;

  localparam int BYTE_W = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    DONE = 2'd2
  } state_e;

endpackage

// File: rtl/ccff_bitstream_loader_byte_serializer.sv
// Byte serializer: holds the current bitstream byte and presents it MSB-first
// on the registered chain head/shift-enable pins. Requests the next byte on
// the final bit of the current one so consecutive bytes shift with no bubble.
module ccff_byte_serializer
  import ccff_loader_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic              CK,
  input  logic              RST,
  input  logic              active,
  input  logic [CNT_W-1:0]  bits_left,
  input  logic              s_valid,
  input  logic [BYTE_W-1:0] s_data,
  output logic              s_ready,
  output logic              ccff_head,
  output logic              ccff_shift_en
);

  logic [BYTE_W-1:0] shreg_q, shreg_d;
  logic [3:0]        nib_q, nib_d;
  logic              head_q, head_d;
  logic              shift_en_q, shift_en_d;
  logic              accept;
  logic              last_shift;

  // Ready when the byte is exhausted (or about to be) and the chain still has
  // room for more bits than are already buffered.
  always_comb begin
    s_ready    = active
                 && ((nib_q == 4'd0) || ((nib_q == 4'd1) && shift_en_q))
                 && (CNT_W'(nib_q) < bits_left);
    accept     = s_valid && s_ready;
    last_shift = shift_en_q && (bits_left == CNT_W'(1));
  end

  // Next byte/bit state; head and shift enable are computed from the next
  // state so that both pins come straight from flops.
  always_comb begin
    shreg_d = shreg_q;
    nib_d   = nib_q;
    if (!active || last_shift) begin
      nib_d = 4'd0;
    end else if (accept) begin
      shreg_d = s_data;
      nib_d   = 4'(BYTE_W);
    end else if (shift_en_q) begin
      shreg_d = {shreg_q[BYTE_W-2:0], 1'b0};
      nib_d   = nib_q - 4'd1;
    end
    shift_en_d = (nib_d != 4'd0);
    head_d     = shift_en_d ? shreg_d[BYTE_W-1] : head_q;
  end

  // Serializer registers with synchronous reset.
  always_ff @(posedge CK) begin
    if (RST) begin
      shreg_q    <= '0;
      nib_q      <= '0;
      head_q     <= 1'b0;
      shift_en_q <= 1'b0;
    end else begin
      shreg_q    <= shreg_d;
      nib_q      <= nib_d;
      head_q     <= head_d;
      shift_en_q <= shift_en_d;
    end
  end

  assign ccff_head     = head_q;
  assign ccff_shift_en = shift_en_q;

endmodule

// File: rtl/ccff_bitstream_loader.sv
// Configuration-chain loader: sequences one load of NUM_BITS bits into the
// fabric chain and accumulates the parity of the bits leaving the tail.
//
//   state | meaning
//   IDLE  | after reset, waiting for start
//   LOAD  | streaming bytes into the chain head
//   DONE  | all NUM_BITS shifted, done held high until the next start
module ccff_bitstream_loader
  import ccff_loader_pkg::*;
#(
  parameter int NUM_BITS = 128,
  parameter int CNT_W    = 16
) (
  input  logic              CK,
  input  logic              RST,
  input  logic              start,
  input  logic              s_valid,
  output logic              s_ready,
  input  logic [BYTE_W-1:0] s_data,
  output logic              ccff_head,
  output logic              ccff_shift_en,
  input  logic              ccff_tail,
  output logic              busy,
  output logic              done,
  output logic              tail_parity
);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] bits_left_q, bits_left_d;
  logic             parity_q, parity_d;

  // Bits remaining is a down-counter; reaching zero ends the load.
  always_comb begin
    state_d     = state_q;
    bits_left_d = bits_left_q;
    parity_d    = parity_q;
    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          state_d     = LOAD;
          bits_left_d = CNT_W'(NUM_BITS);
          parity_d    = 1'b0;
        end
      end
      LOAD: begin
        if (ccff_shift_en) begin
          parity_d    = parity_q ^ ccff_tail;
          bits_left_d = bits_left_q - CNT_W'(1);
          if (bits_left_q == CNT_W'(1)) begin
            state_d = DONE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // FSM, bit counter and tail parity registers.
  always_ff @(posedge CK) begin
    if (RST) begin
      state_q     <= IDLE;
      bits_left_q <= '0;
      parity_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      bits_left_q <= bits_left_d;
      parity_q    <= parity_d;
    end
  end

  ccff_byte_serializer #(
    .CNT_W(CNT_W)
  ) u_ser (
    .CK           (CK),
    .RST          (RST),
    .active       (state_q == LOAD),
    .bits_left    (bits_left_q),
    .s_valid      (s_valid),
    .s_data       (s_data),
    .s_ready      (s_ready),
    .ccff_head    (ccff_head),
    .ccff_shift_en(ccff_shift_en)
  );

  assign busy        = (state_q == LOAD);
  assign done        = (state_q == DONE);
  assign tail_parity = parity_q;

endmodule

// File: tb/tb_ccff_bitstream_loader.sv
// Bench for the configuration-chain loader (NUM_BITS=20, partial final byte).
module tb_ccff_bitstream_loader;

  localparam int NB  = 20;
  localparam int NBY = (NB + 7) / 8;

  logic       CK = 1'b0;
  logic       RST = 1'b1;
  logic       start = 1'b0;
  logic       s_valid = 1'b0;
  logic       s_ready;
  logic [7:0] s_data = 8'h00;
  logic       ccff_head;
  logic       ccff_shift_en;
  logic       ccff_tail = 1'b0;
  logic       busy;
  logic       done;
  logic       tail_parity;

  always #5 CK = ~CK;

  ccff_bitstream_loader #(
    .NUM_BITS(NB),
    .CNT_W   (16)
  ) dut (
    .CK           (CK),
    .RST          (RST),
    .start        (start),
    .s_valid      (s_valid),
    .s_ready      (s_ready),
    .s_data       (s_data),
    .ccff_head    (ccff_head),
    .ccff_shift_en(ccff_shift_en),
    .ccff_tail    (ccff_tail),
    .busy         (busy),
    .done         (done),
    .tail_parity  (tail_parity)
  );

  int         compared = 0;
  int         mismatched = 0;
  bit         exp_q[$];
  bit         tail_bits[NB];
  logic [7:0] bytes_v[NBY];
  bit         exp_par;
  int         shift_cnt, hs_cnt, tail_idx, cyc, first_sh, last_sh;
  logic       prev_head = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Watches the chain pins: every shift cycle pops the next expected head bit.
  task automatic monitor();
    bit e;
    bit sh;
    forever begin
      @(negedge CK);
      cyc++;
      sh = 1'b0;
      if (!RST) begin
        if (ccff_shift_en) begin
          sh = 1'b1;
          if (exp_q.size() == 0) begin
            compared++;
            mismatched++;
            $display("FAIL unexpected_shift: got shift %0d expected none beyond %0d", shift_cnt + 1, NB);
          end else begin
            e = exp_q.pop_front();
            chk("head_bit", ccff_head, e);
          end
          if (shift_cnt == 0) first_sh = cyc;
          last_sh = cyc;
          shift_cnt++;
        end else if (busy) begin
          chk("head_hold", ccff_head, prev_head);
        end
        if (s_valid && s_ready) hs_cnt++;
      end
      prev_head = ccff_head;
      @(posedge CK);
      #1;
      if (sh) begin
        tail_idx++;
        ccff_tail = (tail_idx < NB) ? tail_bits[tail_idx] : 1'b0;
      end
    end
  endtask

  // Builds the expected head sequence and tail parity, then pulses start.
  task automatic start_load();
    exp_q.delete();
    exp_par = 1'b0;
    for (int i = 0; i < NB; i++) begin
      exp_q.push_back(bytes_v[i / 8][7 - (i % 8)]);
      tail_bits[i] = 1'($urandom_range(0, 1));
      exp_par ^= tail_bits[i];
    end
    shift_cnt = 0;
    hs_cnt    = 0;
    tail_idx  = 0;
    ccff_tail = tail_bits[0];
    start = 1'b1;
    @(posedge CK);
    #1;
    start = 1'b0;
    chk("busy_after_start", busy, 1);
    chk("done_after_start", done, 0);
    chk("parity_clear", tail_parity, 0);
  endtask

  task automatic feed_byte(input logic [7:0] b);
    bit ok;
    ok = 1'b0;
    s_valid = 1'b1;
    s_data  = b;
    for (int k = 0; k < 64; k++) begin
      @(negedge CK);
      if (s_ready) begin
        ok = 1'b1;
        break;
      end
    end
    chk("handshake_seen", ok, 1);
    @(posedge CK);
    #1;
    s_valid = 1'b0;
    s_data  = 8'($urandom);
  endtask

  task automatic do_load(input int gap_at, input int gap_len, input bit mid_start,
                         input bit check_contig);
    bit ok;
    start_load();
    for (int b = 0; b < NBY; b++) begin
      if (b == gap_at) begin
        repeat (gap_len) begin
          @(posedge CK);
          #1;
        end
      end
      if (mid_start && b == 1) begin
        start = 1'b1;
        @(posedge CK);
        #1;
        start = 1'b0;
      end
      feed_byte(bytes_v[b]);
    end
    s_valid = 1'b1;
    s_data  = 8'($urandom);
    ok = 1'b0;
    for (int k = 0; k < 200; k++) begin
      @(negedge CK);
      if (done) begin
        ok = 1'b1;
        break;
      end
    end
    chk("done_reached", ok, 1);
    chk("busy_at_done", busy, 0);
    chk("shift_en_at_done", ccff_shift_en, 0);
    chk("shift_count", shift_cnt, NB);
    chk("handshakes", hs_cnt, NBY);
    chk("head_queue_empty", exp_q.size(), 0);
    chk("tail_parity", tail_parity, exp_par);
    if (check_contig) chk("contiguous_shifts", last_sh - first_sh + 1, NB);
    repeat (3) begin
      @(negedge CK);
      chk("ready_after_last", s_ready, 0);
    end
    chk("handshakes_after_hold", hs_cnt, NBY);
    @(posedge CK);
    #1;
    s_valid = 1'b0;
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_s_ready"}, s_ready, 0);
    chk({tag, "_head"}, ccff_head, 0);
    chk({tag, "_shift_en"}, ccff_shift_en, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_done"}, done, 0);
    chk({tag, "_parity"}, tail_parity, 0);
  endtask

  initial begin
    bit ok;
    fork
      monitor();
    join_none

    RST = 1'b1;
    start = 1'b1;
    repeat (3) @(posedge CK);
    #1;
    start = 1'b0;
    check_reset_outputs("reset");
    RST = 1'b0;
    @(posedge CK);
    #1;

    // Back-to-back bytes from the worked example.
    bytes_v[0] = 8'hA5;
    bytes_v[1] = 8'h3C;
    bytes_v[2] = 8'hF0;
    do_load(-1, 0, 1'b0, 1'b1);

    // Starvation gap between first and second byte (load starts from DONE).
    for (int b = 0; b < NBY; b++) bytes_v[b] = 8'($urandom);
    do_load(1, 13, 1'b0, 1'b0);

    // start pulsed mid-load is ignored.
    for (int b = 0; b < NBY; b++) bytes_v[b] = 8'($urandom);
    do_load(-1, 0, 1'b1, 1'b0);

    // Random gaps and data.
    for (int n = 0; n < 6; n++) begin
      for (int b = 0; b < NBY; b++) bytes_v[b] = 8'($urandom);
      do_load($urandom_range(0, NBY - 1), $urandom_range(0, 15), 1'b0, 1'b0);
    end

    // Reset after nine bits have shifted.
    for (int b = 0; b < NBY; b++) bytes_v[b] = 8'($urandom);
    start_load();
    feed_byte(bytes_v[0]);
    feed_byte(bytes_v[1]);
    ok = 1'b0;
    for (int k = 0; k < 64; k++) begin
      @(negedge CK);
      if (shift_cnt >= 9) begin
        ok = 1'b1;
        break;
      end
    end
    chk("reached_nine_bits", ok, 1);
    @(posedge CK);
    #1;
    RST = 1'b1;
    start = 1'b1;
    @(posedge CK);
    #1;
    start = 1'b0;
    check_reset_outputs("midload_reset");
    RST = 1'b0;
    exp_q.delete();
    @(posedge CK);
    #1;
    check_reset_outputs("after_reset");

    // Fresh load after the interrupted one.
    bytes_v[0] = 8'hFF;
    bytes_v[1] = 8'h00;
    bytes_v[2] = 8'($urandom);
    do_load(-1, 0, 1'b0, 1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
